// File: rtl/seq_muladd.sv
`default_nettype none
// ============================================================================
// Module   : seq_muladd
// Purpose  : Iterative shift-add multiply-accumulate, p = b*q + r, one
//            partial product per cycle (inverse check of the divider).
// Revision : 1.0  initial release
// ============================================================================
module seq_muladd #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   q_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  input  logic [DATA_WIDTH-1:0]   r_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] p_out,
  output logic                    busy
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic [PW-1:0]   step_sum;

  // Partial-product add for the current multiplier LSB.
  assign step_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d    = {{W{1'b0}}, r_in};
          mcand_d  = {{W{1'b0}}, b_in};
          mplier_d = q_in;
          cnt_d    = CW'(W);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Always W steps, even once the multiplier is exhausted, for fixed latency.
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = step_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign p_out     = p_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_muladd.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_muladd
// Purpose  : Self-checking bench for seq_muladd against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_muladd;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   q_in, b_in, r_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p_out;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_muladd #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .b_in      (b_in),
    .r_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_out     (p_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_muladd(input logic [W-1:0] q, input logic [W-1:0] b,
                                             input logic [W-1:0] r);
    return 64'(b) * 64'(q) + 64'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand set and wait for its result; leaves the block in DONE.
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r,
                        input string tag);
    int n;
    logic [63:0] exp_v;
    exp_v = ref_muladd(q, b, r);
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check_val({tag, " ready"}, 64'(in_ready), 64'd1);
    q_in = q; b_in = b; r_in = r;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    q_in = W'($urandom); b_in = W'($urandom); r_in = W'($urandom);
    check_val({tag, " busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check_val({tag, " latency"}, 64'(n), 64'(W));
    check_val({tag, " p_out"}, 64'(p_out), exp_v);
  endtask

  task automatic handshake(input string tag);
    logic [2*W-1:0] held;
    held = p_out;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val({tag, " idle"}, 64'(in_ready), 64'd1);
    check_val({tag, " ov_low"}, 64'(out_valid), 64'd0);
    check_val({tag, " p_hold"}, 64'(p_out), 64'(held));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]   rq, rb, rr;
    logic [2*W-1:0] held;
    logic [63:0]    exp_q[$];
    int n, n_acc, n_out, last_t, seen_ov;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q_in = '0; b_in = '0; r_in = '0;
    step();
    step();
    check_val("rst in_ready", 64'(in_ready), 64'd1);
    check_val("rst busy", 64'(busy), 64'd0);
    check_val("rst out_valid", 64'(out_valid), 64'd0);
    check_val("rst p_out", 64'(p_out), 64'd0);
    rst = 1'b0;

    // Accept on the first edge after reset release; 7*3+2.
    run_op(16'd7, 16'd3, 16'd2, "basic");
    check_val("basic const", 64'(p_out), 64'd23);
    handshake("basic");

    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, "max");
    check_val("max const", 64'(p_out), 64'hFFFF_0000);
    handshake("max");

    run_op(16'd1234, 16'd0, 16'd5, "b_zero");
    handshake("b_zero");
    run_op(16'd0, 16'd999, 16'd0, "q_zero");
    handshake("q_zero");

    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), "rand");
      handshake("rand");
    end

    // Backpressure in DONE with in_valid high and toggling operands.
    run_op(16'd50, 16'd60, 16'd7, "stall");
    held = p_out;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q_in = W'($urandom); b_in = W'($urandom); r_in = W'($urandom);
      step();
      check_val("stall ov", 64'(out_valid), 64'd1);
      check_val("stall p", 64'(p_out), 64'(held));
      check_val("stall rdy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    handshake("stall");
    step();
    check_val("stall no_accept", 64'(busy), 64'd0);

    // Reset in the eighth RUN cycle aborts the operation.
    q_in = 16'd11; b_in = 16'd13; r_in = 16'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_val("abort pre busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("abort ov", 64'(out_valid), 64'd0);
    check_val("abort p", 64'(p_out), 64'd0);
    check_val("abort rdy", 64'(in_ready), 64'd1);
    check_val("abort busy", 64'(busy), 64'd0);
    seen_ov = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) seen_ov++;
    end
    check_val("abort no_result", 64'(seen_ov), 64'd0);
    run_op(16'd100, 16'd200, 16'd0, "post_abort");
    check_val("post_abort const", 64'(p_out), 64'd20000);
    handshake("post_abort");

    // Streaming with both handshakes held high.
    in_valid = 1'b1;
    out_ready = 1'b1;
    n_acc = 0; n_out = 0; last_t = -1;
    for (int t = 0; t < 8 * 18 + 40 && n_out < 8; t++) begin
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          check_val("stream p", 64'(p_out), exp_q.pop_front());
        end else begin
          check_val("stream spurious", 64'd1, 64'd0);
        end
        n_out++;
      end
      if (in_ready && n_acc < 8) begin
        rq = W'($urandom); rb = W'($urandom); rr = W'($urandom);
        q_in = rq; b_in = rb; r_in = rr;
        exp_q.push_back(ref_muladd(rq, rb, rr));
        if (last_t >= 0) check_val("stream interval", 64'(t - last_t), 64'd18);
        last_t = t;
        n_acc++;
      end else begin
        if (in_ready) in_valid = 1'b0;
        q_in = W'($urandom); b_in = W'($urandom); r_in = W'($urandom);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_val("stream outputs", 64'(n_out), 64'd8);
    n = exp_q.size();
    check_val("stream drained", 64'(n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
